sm83_alu_seq: RTL and testbench

//  Nibble-serial shift/rotate and decimal-adjust sequencer for words of NIBBLES digits, one ALU_WIDTH slice per cycle.

---
 rtl/sm83_alu_seq_pkg.sv | 49 ++++
 rtl/sm83_alu_seq_slice.sv | 64 ++++++
 rtl/sm83_alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_sm83_alu_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_alu_seq_pkg.sv
// Shared types and helpers for the nibble-serial shift/DAA sequencer.
// Optional feature macro used by the top: SM83_ALU_SEQ_COND_EN.
`timescale 1ns/1ps
package sm83_alu_seq_pkg;

  // One default-width ALU slice (a BCD digit).
  typedef logic [3:0] hword_t;

  // CB-prefix shift/rotate selector, encoded as the opcode's bits 5:3.
  typedef enum logic [2:0] {
    RLC  = 3'd0,
    RRC  = 3'd1,
    RL   = 3'd2,
    RR   = 3'd3,
    SLA  = 3'd4,
    SRA  = 3'd5,
    SWAP = 3'd6,
    SRL  = 3'd7
  } op543_e;

  // Sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Per-digit decimal-adjust correction.
  localparam hword_t DAA_CORR = 4'h6;

  // Right shifts/rotates walk the word from the most significant slice down.
  function automatic logic is_right_op(op543_e op);
    return (op == RRC) || (op == RR) || (op == SRA) || (op == SRL);
  endfunction

  // Carry seeded into the first slice of a shift, taken from the whole operand.
  function automatic logic init_carry(op543_e op, logic msb, logic lsb, logic cin);
    logic c;
    case (op)
      RLC:     c = msb;
      RRC:     c = lsb;
      RL:      c = cin;
      RR:      c = cin;
      SRA:     c = msb;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sm83_alu_seq_slice.sv
// Combinational datapath for one ALU slice: shift/rotate by one bit or one
// decimal-adjust digit, with the carry/borrow and "greater than nine" chains
// passed slice to slice by the sequencer.
`timescale 1ns/1ps
module sm83_alu_slice
  import sm83_alu_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         daa_i,
  input  logic         sub_i,
  input  op543_e       op_i,
  input  logic [W-1:0] nib_i,
  input  logic         carry_i,
  input  logic         gt_i,
  input  logic         flag_i,
  output logic [W-1:0] nib_o,
  output logic         carry_o,
  output logic         gt_o
);

  localparam logic [W-1:0] NINE   = W'(9);
  localparam logic [W:0]   CORR_W = (W+1)'(DAA_CORR);

  logic         corr;
  logic [W:0]   sum;

  // Select between the one-bit shift network and the decimal-adjust digit adder.
  always_comb begin
    nib_o   = nib_i;
    carry_o = 1'b0;
    gt_o    = 1'b0;
    corr    = 1'b0;
    sum     = '0;
    if (daa_i) begin
      gt_o = (nib_i > NINE) | ((nib_i == NINE) & gt_i);
      if (sub_i) begin
        corr    = flag_i;
        sum     = {1'b0, nib_i} - (corr ? CORR_W : '0) - {{W{1'b0}}, carry_i};
      end else begin
        corr    = gt_o | flag_i;
        sum     = {1'b0, nib_i} + (corr ? CORR_W : '0) + {{W{1'b0}}, carry_i};
      end
      nib_o   = sum[W-1:0];
      carry_o = sum[W];
    end else begin
      case (op_i)
        RLC, RL, SLA: begin
          nib_o   = {nib_i[W-2:0], carry_i};
          carry_o = nib_i[W-1];
        end
        RRC, RR, SRA, SRL: begin
          nib_o   = {carry_i, nib_i[W-1:1]};
          carry_o = nib_i[0];
        end
        default: begin
          nib_o   = nib_i;
          carry_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sm83_alu_seq.sv
// Nibble-serial shift/rotate and decimal-adjust sequencer. Processes one
// ALU_WIDTH slice per clock, reporting result and flags with a done pulse.
// Optional macro SM83_ALU_SEQ_COND_EN adds a registered branch-condition
// evaluator over the held zero/carry flags.
`timescale 1ns/1ps
module sm83_alu_seq
  import sm83_alu_seq_pkg::*;
#(
  parameter  int ALU_WIDTH = 4,
  parameter  int NIBBLES   = 2,
  localparam int WORD_SIZE = ALU_WIDTH * NIBBLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 daa,
  input  logic [2:0]           op543,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 carry_in,
  input  logic                 half_carry_in,
  input  logic                 subtract,
  input  logic                 cond_we,
  input  logic [1:0]           cond_sel,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry_out,
  output logic                 zero_out,
  output logic                 cond_result
);

  localparam int              IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (ALU_WIDTH != 4) begin : g_width_check
    $error("sm83_alu_seq: decimal adjust requires ALU_WIDTH == 4");
  end
  if (NIBBLES < 2) begin : g_nibbles_check
    $error("sm83_alu_seq: NIBBLES must be at least 2");
  end

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WORD_SIZE-1:0]   opnd_q;
  logic [WORD_SIZE-1:0]   work_q;
  logic [WORD_SIZE-1:0]   work_d;
  logic                   c_q;
  logic                   gt_q;
  logic                   daa_q;
  logic                   sub_q;
  op543_e                 op_q;
  logic                   cin_q;
  logic                   hin_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WORD_SIZE-1:0]   result_q;
  logic                   carry_q;
  logic                   zero_q;

  logic [IDX_W-1:0]       pos;
  logic [IDX_W-1:0]       src_idx;
  logic [ALU_WIDTH-1:0]   nib_in;
  logic                   flag;
  logic [ALU_WIDTH-1:0]   nib_out;
  logic                   c_out;
  logic                   gt_out;
  logic                   carry_d;

  // Pick this cycle's slice: destination position, source nibble and DAA digit flag.
  always_comb begin
    pos     = idx_q;
    src_idx = idx_q;
    flag    = 1'b0;
    if (!daa_q && is_right_op(op_q)) begin
      pos     = LAST_IDX - idx_q;
      src_idx = LAST_IDX - idx_q;
    end else if (!daa_q && (op_q == SWAP)) begin
      src_idx = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    end
    if (daa_q) begin
      if (idx_q == '0) begin
        flag = hin_q;
      end else if (idx_q == LAST_IDX) begin
        flag = cin_q;
      end
    end
    nib_in = opnd_q[src_idx*ALU_WIDTH +: ALU_WIDTH];
  end

  sm83_alu_slice #(
    .W (ALU_WIDTH)
  ) u_slice (
    .daa_i   (daa_q),
    .sub_i   (sub_q),
    .op_i    (op_q),
    .nib_i   (nib_in),
    .carry_i (c_q),
    .gt_i    (gt_q),
    .flag_i  (flag),
    .nib_o   (nib_out),
    .carry_o (c_out),
    .gt_o    (gt_out)
  );

  // Merge the slice into the partial word and form the carry the op reports when it finishes.
  always_comb begin
    work_d = work_q;
    work_d[pos*ALU_WIDTH +: ALU_WIDTH] = nib_out;
    if (daa_q) begin
      carry_d = sub_q ? cin_q : (gt_out | cin_q);
    end else if (op_q == SWAP) begin
      carry_d = 1'b0;
    end else begin
      carry_d = c_out;
    end
  end

  // Sequencer: accept an operand, walk the slices, then publish result and flags with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      c_q      <= 1'b0;
      gt_q     <= 1'b0;
      daa_q    <= 1'b0;
      sub_q    <= 1'b0;
      op_q     <= RLC;
      cin_q    <= 1'b0;
      hin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            opnd_q  <= data_in;
            work_q  <= '0;
            daa_q   <= daa;
            sub_q   <= subtract;
            op_q    <= op543_e'(op543);
            cin_q   <= carry_in;
            hin_q   <= half_carry_in;
            gt_q    <= 1'b0;
            c_q     <= daa ? 1'b0 : init_carry(op543_e'(op543), data_in[WORD_SIZE-1],
                                               data_in[0], carry_in);
          end
        end
        RUN: begin
          work_q <= work_d;
          c_q    <= c_out;
          gt_q   <= gt_out;
          if (idx_q == LAST_IDX) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= work_d;
            carry_q  <= carry_d;
            zero_q   <= (work_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SM83_ALU_SEQ_COND_EN
  logic cond_q;

  // Evaluate the selected branch condition against the currently held flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q <= 1'b0;
    end else if (cond_we) begin
      case (cond_sel)
        2'd0:    cond_q <= ~zero_q;
        2'd1:    cond_q <= zero_q;
        2'd2:    cond_q <= ~carry_q;
        default: cond_q <= carry_q;
      endcase
    end
  end

  assign cond_result = cond_q;
`else
  logic cond_unused;
  assign cond_unused = ^{cond_we, cond_sel};
  assign cond_result = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Directed bench for sm83_alu_seq: a two-digit instance driven from a vector
// table plus hand sequences, and a four-digit instance for multi-digit DAA.
// Honours SM83_ALU_SEQ_COND_EN for the condition-register expectations.
`timescale 1ns/1ps
module tb_sm83_alu_seq;

  typedef struct {
    string      name;
    logic       daa;
    logic [2:0] op;
    logic [7:0] data;
    logic       cin;
    logic       hin;
    logic       sub;
    logic [7:0] expResult;
    logic       expCarry;
    logic       expZero;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start2 = 1'b0;
  logic        start4 = 1'b0;
  logic        daa = 1'b0;
  logic [2:0]  op543 = 3'd0;
  logic [7:0]  dataIn2 = 8'h00;
  logic [15:0] dataIn4 = 16'h0000;
  logic        carryIn = 1'b0;
  logic        halfCarryIn = 1'b0;
  logic        subtract = 1'b0;
  logic        condWe = 1'b0;
  logic [1:0]  condSel = 2'd0;

  logic        busy2, done2, carry2, zero2, cond2;
  logic [7:0]  result2;
  logic        busy4, done4, carry4, zero4, cond4;
  logic [15:0] result4;

  int total = 0;
  int bad = 0;
  logic expCond;

  vec_t vecs[12];

  always #5 clk = ~clk;

  sm83_alu_seq #(.ALU_WIDTH(4), .NIBBLES(2)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .start         (start2),
    .daa           (daa),
    .op543         (op543),
    .data_in       (dataIn2),
    .carry_in      (carryIn),
    .half_carry_in (halfCarryIn),
    .subtract      (subtract),
    .cond_we       (condWe),
    .cond_sel      (condSel),
    .busy          (busy2),
    .done          (done2),
    .result        (result2),
    .carry_out     (carry2),
    .zero_out      (zero2),
    .cond_result   (cond2)
  );

  sm83_alu_seq #(.ALU_WIDTH(4), .NIBBLES(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .start         (start4),
    .daa           (daa),
    .op543         (op543),
    .data_in       (dataIn4),
    .carry_in      (carryIn),
    .half_carry_in (halfCarryIn),
    .subtract      (subtract),
    .cond_we       (1'b0),
    .cond_sel      (2'd0),
    .busy          (busy4),
    .done          (done4),
    .result        (result4),
    .carry_out     (carry4),
    .zero_out      (zero4),
    .cond_result   (cond4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  // Drive one operation into the two-digit instance; returns just after the accepting edge.
  task automatic applyStimulus(input logic d, input logic [2:0] op, input logic [7:0] data,
                               input logic c, input logic h, input logic n);
    daa         = d;
    op543       = op;
    dataIn2     = data;
    carryIn     = c;
    halfCarryIn = h;
    subtract    = n;
    start2      = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
  endtask

  // Run one op and check busy during cycles 0..1 and done/result/flags at cycle 2.
  task automatic runOp(input vec_t v);
    applyStimulus(v.daa, v.op, v.data, v.cin, v.hin, v.sub);
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      checkOutput({v.name, " busy"}, {31'd0, busy2}, 32'd1);
      checkOutput({v.name, " early done"}, {31'd0, done2}, 32'd0);
    end
    @(negedge clk);
    checkOutput({v.name, " done"}, {31'd0, done2}, 32'd1);
    checkOutput({v.name, " idle at done"}, {31'd0, busy2}, 32'd0);
    checkOutput({v.name, " result"}, {24'd0, result2}, {24'd0, v.expResult});
    checkOutput({v.name, " carry"}, {31'd0, carry2}, {31'd0, v.expCarry});
    checkOutput({v.name, " zero"}, {31'd0, zero2}, {31'd0, v.expZero});
  endtask

  initial begin
    //          name        daa   op    data   cin   hin   sub   result c     z
    vecs[0]  = '{"rlc85",   1'b0, 3'd0, 8'h85, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b1, 1'b0};
    vecs[1]  = '{"rr01",    1'b0, 3'd3, 8'h01, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[2]  = '{"sra81",   1'b0, 3'd5, 8'h81, 1'b0, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0};
    vecs[3]  = '{"swapA5",  1'b0, 3'd6, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[4]  = '{"srl01",   1'b0, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{"sla81",   1'b0, 3'd4, 8'h81, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[6]  = '{"rl80",    1'b0, 3'd2, 8'h80, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[7]  = '{"rrc01",   1'b0, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[8]  = '{"daaSub0F",1'b1, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0};
    vecs[9]  = '{"daaAdd45",1'b1, 3'd0, 8'h45, 1'b0, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[10] = '{"daaSub60",1'b1, 3'd0, 8'h60, 1'b1, 1'b1, 1'b1, 8'hFA, 1'b1, 1'b0};
    vecs[11] = '{"daaAdd9A",1'b1, 3'd0, 8'h9A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy2}, 32'd0);
    checkOutput("reset done", {31'd0, done2}, 32'd0);
    checkOutput("reset result", {24'd0, result2}, 32'd0);
    checkOutput("reset carry", {31'd0, carry2}, 32'd0);
    checkOutput("reset zero", {31'd0, zero2}, 32'd0);
    checkOutput("reset cond", {31'd0, cond2}, 32'd0);
    checkOutput("reset busy4", {31'd0, busy4}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, each started in the previous op's done cycle
    for (int i = 0; i < 12; i++) begin
      runOp(vecs[i]);
    end

    // Condition register over the flags left by the 0x9A adjust (Z=1, C=1)
    condWe  = 1'b1;
    condSel = 2'd1;
    @(posedge clk);
    #1 condSel = 2'd2;
    @(negedge clk);
`ifdef SM83_ALU_SEQ_COND_EN
    expCond = 1'b1;
`else
    expCond = 1'b0;
`endif
    checkOutput("cond Z", {31'd0, cond2}, {31'd0, expCond});
    @(posedge clk);
    #1 condWe = 1'b0;
    @(negedge clk);
    checkOutput("cond NC", {31'd0, cond2}, 32'd0);

    // start while busy must be ignored
    applyStimulus(1'b0, 3'd0, 8'h85, 1'b0, 1'b0, 1'b0);
    op543   = 3'd7;
    dataIn2 = 8'h00;
    start2  = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    checkOutput("ignore busy c1", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    checkOutput("ignore done", {31'd0, done2}, 32'd1);
    checkOutput("ignore result", {24'd0, result2}, 32'h0B);
    checkOutput("ignore carry", {31'd0, carry2}, 32'd1);
    @(negedge clk);
    checkOutput("ignore idle busy", {31'd0, busy2}, 32'd0);
    checkOutput("ignore idle done", {31'd0, done2}, 32'd0);

    // Reset in the middle of a run aborts without a done pulse
    applyStimulus(1'b0, 3'd6, 8'hA5, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", {31'd0, busy2}, 32'd0);
    checkOutput("abort done", {31'd0, done2}, 32'd0);
    checkOutput("abort result", {24'd0, result2}, 32'd0);
    checkOutput("abort carry", {31'd0, carry2}, 32'd0);
    checkOutput("abort zero", {31'd0, zero2}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort no done", {31'd0, done2}, 32'd0);
    end

    // Four-digit decimal adjust: 0x099A -> 0x1000, done at cycle 4
    daa         = 1'b1;
    op543       = 3'd0;
    dataIn4     = 16'h099A;
    carryIn     = 1'b0;
    halfCarryIn = 1'b0;
    subtract    = 1'b0;
    start4      = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checkOutput("daa4 busy", {31'd0, busy4}, 32'd1);
      checkOutput("daa4 early done", {31'd0, done4}, 32'd0);
    end
    @(negedge clk);
    checkOutput("daa4 done", {31'd0, done4}, 32'd1);
    checkOutput("daa4 result", {16'd0, result4}, 32'h1000);
    checkOutput("daa4 carry", {31'd0, carry4}, 32'd0);
    checkOutput("daa4 zero", {31'd0, zero4}, 32'd0);
    checkOutput("daa4 cond", {31'd0, cond4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
